// File: rtl/cyt_rdma_hls_deadlock_monitor_param.sv
// rtl/cyt_rdma_hls_deadlock_monitor_param.sv - hierarchical AXIS stall deadlock monitor
// Declares a block after THRESHOLD consecutive stalled cycles and records detection history.
module cyt_rdma_hls_deadlock_monitor_param #(
  parameter int                           NUM_AXIS  = 12,
  parameter int                           NUM_SUB   = 2,
  parameter logic [NUM_AXIS-1:0]          CUR_MASK  = 12'h070,
  parameter logic [NUM_SUB*NUM_AXIS-1:0]  SUB_MASK  = {12'h600, 12'h180},
  parameter int                           THRESHOLD = 1,
  parameter int                           EVT_W     = 16,
  localparam int                          IDX_W     = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_SUB-1:0]  sub_block,
  input  logic                clear,
  output logic                block,
  output logic                block_sticky,
  output logic                detect_pulse,
  output logic [IDX_W-1:0]    first_idx,
  output logic                first_valid,
  output logic [EVT_W-1:0]    event_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COUNTING = 2'd1;
  localparam logic [1:0] S_DETECTED = 2'd2;

  localparam logic [8:0]       TH9     = 9'(THRESHOLD);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [1:0]          state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic [NUM_AXIS-1:0] contrib;
  logic                seq_block;
  logic [IDX_W-1:0]    low_idx;
  logic                enter_det;
  logic [EVT_W-1:0]    evt_base;
  logic                valid_base;

  // A child's AXIS bits only count while that child itself reports a block.
  always_comb begin
    contrib = axis_block_sigs & CUR_MASK;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (sub_block[i]) begin
        contrib = contrib | (axis_block_sigs & SUB_MASK[i*NUM_AXIS +: NUM_AXIS]);
      end
    end
  end

  assign seq_block = |contrib;

  always_comb begin
    low_idx = '0;
    for (int b = NUM_AXIS - 1; b >= 0; b--) begin
      if (contrib[b]) begin
        low_idx = IDX_W'(b);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (!seq_block) begin
          cnt_nxt = 8'd0;
        end else if (THRESHOLD <= 1) begin
          state_nxt = S_DETECTED;
        end else begin
          state_nxt = S_COUNTING;
          cnt_nxt   = 8'd1;
        end
      end
      S_COUNTING: begin
        if (!seq_block) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else if ({1'b0, cnt} + 9'd1 == TH9) begin
          state_nxt = S_DETECTED;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_DETECTED: begin
        if (!seq_block) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign enter_det = (state_nxt == S_DETECTED) && (state != S_DETECTED);

  // Clear takes effect first so a coincident entry is recorded on fresh history.
  assign evt_base   = clear ? '0 : event_count;
  assign valid_base = clear ? 1'b0 : first_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      block        <= 1'b0;
      block_sticky <= 1'b0;
      detect_pulse <= 1'b0;
      first_idx    <= '0;
      first_valid  <= 1'b0;
      event_count  <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      block        <= (state_nxt == S_DETECTED);
      detect_pulse <= enter_det;
      block_sticky <= enter_det | (block_sticky & ~clear);
      if (enter_det && evt_base != EVT_MAX) begin
        event_count <= evt_base + EVT_W'(1);
      end else begin
        event_count <= evt_base;
      end
      if (enter_det && !valid_base) begin
        first_idx   <= low_idx;
        first_valid <= 1'b1;
      end else begin
        first_idx   <= clear ? '0 : first_idx;
        first_valid <= valid_base;
      end
    end
  end

endmodule

// File: tb/tb_cyt_rdma_hls_deadlock_monitor_param.sv
// tb/tb_cyt_rdma_hls_deadlock_monitor_param.sv - bench for three monitor configurations
// Instances: 0 defaults, 1 THRESHOLD=4, 2 EVT_W=2; all share one stimulus stream.
module tb_cyt_rdma_hls_deadlock_monitor_param;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [11:0] axis  = '0;
  logic [1:0]  sub   = '0;
  logic        clr   = 1'b0;

  logic        blk [3];
  logic        stk [3];
  logic        pls [3];
  logic        fvd [3];
  logic [3:0]  fix [3];
  logic [15:0] evc [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int TH = (g == 1) ? 4 : 1;
    localparam int EW = (g == 2) ? 2 : 16;
    logic          b_w, s_w, p_w, v_w;
    logic [3:0]    i_w;
    logic [EW-1:0] e_w;
    cyt_rdma_hls_deadlock_monitor_param #(.THRESHOLD(TH), .EVT_W(EW)) u_dut (
      .clock           (clock),
      .reset           (rst),
      .axis_block_sigs (axis),
      .sub_block       (sub),
      .clear           (clr),
      .block           (b_w),
      .block_sticky    (s_w),
      .detect_pulse    (p_w),
      .first_idx       (i_w),
      .first_valid     (v_w),
      .event_count     (e_w)
    );
    assign blk[g] = b_w;
    assign stk[g] = s_w;
    assign pls[g] = p_w;
    assign fvd[g] = v_w;
    assign fix[g] = i_w;
    assign evc[g] = 16'(e_w);
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  int th    [3] = '{1, 4, 1};
  int evmax [3] = '{65535, 65535, 3};

  // Model: run length of consecutive contributing cycles decides everything.
  int  run   [3];
  bit  m_blk [3];
  bit  m_stk [3];
  bit  m_pls [3];
  bit  m_fvd [3];
  int  m_fix [3];
  int  m_evc [3];
  logic [11:0] m_c;

  function automatic logic [11:0] contrib(input logic [11:0] a, input logic [1:0] s);
    logic [11:0] c;
    for (int b = 0; b < 12; b++) begin
      c[b] = a[b] && ((b >= 4 && b <= 6) ||
                      (s[0] && (b == 7 || b == 8)) ||
                      (s[1] && (b == 9 || b == 10)));
    end
    return c;
  endfunction

  function automatic int lowest(input logic [11:0] c);
    for (int b = 0; b < 12; b++) begin
      if (c[b]) return b;
    end
    return 0;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      run[k] = 0; m_blk[k] = 0; m_stk[k] = 0; m_pls[k] = 0;
      m_fvd[k] = 0; m_fix[k] = 0; m_evc[k] = 0;
    end
  end

  always @(posedge clock) begin
    m_c = contrib(axis, sub);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        run[k] = 0; m_blk[k] = 0; m_stk[k] = 0; m_pls[k] = 0;
        m_fvd[k] = 0; m_fix[k] = 0; m_evc[k] = 0;
      end else begin
        if (m_c != 0) begin
          if (run[k] < 255) run[k] = run[k] + 1;
        end else begin
          run[k] = 0;
        end
        m_blk[k] = run[k] >= th[k];
        m_pls[k] = (m_c != 0) && (run[k] == th[k]);
        if (clr) begin
          m_stk[k] = 0; m_fvd[k] = 0; m_fix[k] = 0; m_evc[k] = 0;
        end
        if (m_pls[k]) begin
          m_stk[k] = 1;
          if (m_evc[k] < evmax[k]) m_evc[k] = m_evc[k] + 1;
          if (!m_fvd[k]) begin
            m_fvd[k] = 1;
            m_fix[k] = lowest(m_c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, k, $time, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("block", k, longint'(blk[k]), longint'(m_blk[k]));
        chk("block_sticky", k, longint'(stk[k]), longint'(m_stk[k]));
        chk("detect_pulse", k, longint'(pls[k]), longint'(m_pls[k]));
        chk("first_valid", k, longint'(fvd[k]), longint'(m_fvd[k]));
        chk("first_idx", k, longint'(fix[k]), longint'(m_fix[k]));
        chk("event_count", k, longint'(evc[k]), longint'(m_evc[k]));
      end
    end
  end

  task automatic step(input logic [11:0] a, input logic [1:0] s, input logic c, input logic r);
    @(negedge clock);
    axis = a; sub = s; clr = c; rst = r;
    @(posedge clock);
    #1;
  endtask

  int seg_len;
  logic [11:0] seg_a;
  logic [1:0]  seg_s;

  initial begin
    repeat (3) step(12'h000, 2'b00, 1'b0, 1'b1);
    started = 1'b1;
    chk("lit_reset_block", 0, longint'(blk[0]), 0);
    chk("lit_reset_event", 0, longint'(evc[0]), 0);

    // Single owned stall, threshold 1.
    step(12'h000, 2'b00, 1'b0, 1'b0);
    step(12'h010, 2'b00, 1'b0, 1'b0);
    chk("lit17_block", 0, longint'(blk[0]), 1);
    chk("lit17_pulse", 0, longint'(pls[0]), 1);
    chk("lit17_idx", 0, longint'(fix[0]), 4);
    chk("lit17_event", 0, longint'(evc[0]), 1);
    step(12'h010, 2'b00, 1'b0, 1'b0);
    chk("lit17_pulse_once", 0, longint'(pls[0]), 0);
    repeat (3) step(12'h010, 2'b00, 1'b0, 1'b0);
    step(12'h000, 2'b00, 1'b0, 1'b0);
    chk("lit17_release", 0, longint'(blk[0]), 0);
    chk("lit17_sticky", 0, longint'(stk[0]), 1);

    // Threshold 4: a 3-cycle run must not detect, a 4-cycle run must.
    step(12'h000, 2'b00, 1'b1, 1'b0);
    repeat (3) step(12'h010, 2'b00, 1'b0, 1'b0);
    chk("lit18_short_run", 1, longint'(blk[1]), 0);
    step(12'h000, 2'b00, 1'b0, 1'b0);
    repeat (3) step(12'h010, 2'b00, 1'b0, 1'b0);
    chk("lit18_third", 1, longint'(blk[1]), 0);
    step(12'h010, 2'b00, 1'b0, 1'b0);
    chk("lit18_block", 1, longint'(blk[1]), 1);
    chk("lit18_event", 1, longint'(evc[1]), 1);
    step(12'h000, 2'b00, 1'b0, 1'b0);

    // Sub-monitor gating.
    step(12'h000, 2'b00, 1'b1, 1'b0);
    step(12'h200, 2'b00, 1'b0, 1'b0);
    chk("lit19_nosub", 0, longint'(blk[0]), 0);
    step(12'h200, 2'b10, 1'b0, 1'b0);
    chk("lit19_sub1", 0, longint'(blk[0]), 1);
    chk("lit19_idx", 0, longint'(fix[0]), 9);
    step(12'h200, 2'b01, 1'b0, 1'b0);
    chk("lit19_wrong_sub", 0, longint'(blk[0]), 0);
    step(12'h000, 2'b00, 1'b0, 1'b0);

    // Clear coincident with the third entry.
    step(12'h000, 2'b00, 1'b1, 1'b0);
    repeat (2) begin
      step(12'h010, 2'b00, 1'b0, 1'b0);
      step(12'h000, 2'b00, 1'b0, 1'b0);
    end
    step(12'h020, 2'b00, 1'b1, 1'b0);
    chk("lit20_event", 0, longint'(evc[0]), 1);
    chk("lit20_sticky", 0, longint'(stk[0]), 1);
    chk("lit20_valid", 0, longint'(fvd[0]), 1);
    chk("lit20_idx", 0, longint'(fix[0]), 5);
    step(12'h000, 2'b00, 1'b0, 1'b0);

    // Saturation at EVT_W=2 and reset during DETECTED.
    repeat (5) begin
      step(12'h040, 2'b00, 1'b0, 1'b0);
      step(12'h000, 2'b00, 1'b0, 1'b0);
    end
    chk("lit21_saturate", 2, longint'(evc[2]), 3);
    step(12'h040, 2'b00, 1'b0, 1'b0);
    step(12'h040, 2'b00, 1'b1, 1'b1);
    chk("lit21_rst_block", 2, longint'(blk[2]), 0);
    chk("lit21_rst_event", 2, longint'(evc[2]), 0);
    chk("lit21_rst_sticky", 2, longint'(stk[2]), 0);
    step(12'h040, 2'b00, 1'b0, 1'b0);
    chk("lit21_reassert", 2, longint'(blk[2]), 1);
    step(12'h000, 2'b00, 1'b0, 1'b0);

    // Random segments with held patterns so runs reach the higher threshold.
    repeat (80) begin
      seg_len = $urandom_range(1, 6);
      seg_a   = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(0, 4095));
      seg_s   = 2'($urandom_range(0, 3));
      repeat (seg_len) begin
        step(seg_a, seg_s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
      end
    end
    step(12'h000, 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cyt_rdma_hls_deadlock_monitor_param.md
CYT_RDMA_HLS_DEADLOCK_MONITOR_PARAM -- requirements
Module: cyt_rdma_hls_deadlock_monitor_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_AXIS, 12, number of AXIS block-signal bits observed.
- NUM_SUB, 2, number of sub-process monitors feeding this one.
- CUR_MASK, 12'h070, AXIS bits owned directly by this process.
- SUB_MASK, {12'h600,12'h180}, flat NUM_SUB*NUM_AXIS vector; slice i holds AXIS bits tied to sub-monitor i.
- THRESHOLD, 1, consecutive blocked cycles required to declare block; legal range 1..255.
- EVT_W, 16, event-counter width.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clock in 1 sole clock; all logic on its rising edge.
- reset in 1 synchronous, active-high reset.
- axis_block_sigs in NUM_AXIS per-channel AXIS stall flags.
- sub_block in NUM_SUB block outputs of child monitors.
- clear in 1 synchronous clear of sticky, capture and event state.
- block out 1 live deadlock indication.
- block_sticky out 1 latched indication since last clear.
- detect_pulse out 1 one-cycle strobe on each new detection.
- first_idx out IDX_W (=max(1,clog2(NUM_AXIS))) lowest contributing AXIS index of first detection since clear.
- first_valid out 1 first_idx holds valid data.
- event_count out EVT_W number of detections since clear.

Function
REQ-003 Contributing vector C SHALL be (axis_block_sigs & CUR_MASK) OR, for each i with sub_block[i]=1, (axis_block_sigs & SUB_MASK slice i); seq_block = OR-reduce(C).
REQ-004 FSM states SHALL be IDLE, COUNTING, DETECTED with an 8-bit run counter cnt.
REQ-005 IDLE: seq_block=0 -> stay, cnt=0; seq_block=1 and THRESHOLD=1 -> DETECTED; seq_block=1 and THRESHOLD>1 -> COUNTING, cnt=1.
REQ-006 COUNTING: seq_block=0 -> IDLE, cnt=0; seq_block=1 and cnt+1=THRESHOLD -> DETECTED; else cnt increments.
REQ-007 DETECTED: seq_block=1 -> stay; seq_block=0 -> IDLE, cnt=0.
REQ-008 block SHALL be registered, equal to (state==DETECTED); seq_block first high in cycle N with no gaps gives block=1 in cycle N+THRESHOLD.
REQ-009 block SHALL deassert the cycle after seq_block first returns to 0.
REQ-010 Entry into DETECTED SHALL, in the same registered update: assert detect_pulse for exactly one cycle; set block_sticky; increment event_count, saturating at 2^EVT_W-1; if first_valid=0, load first_idx with lowest set index of C and set first_valid.
REQ-011 Re-entry after a return to IDLE SHALL count as a new detection; first_idx SHALL NOT be overwritten while first_valid=1.
REQ-012 clear SHALL zero block_sticky, first_valid, first_idx, event_count next cycle; FSM, cnt and block unaffected.
REQ-013 clear coincident with DETECTED entry: clear applied first, then entry recorded (event_count=1, block_sticky=1, first_valid=1 with new index).
REQ-014 Any mask bit beyond NUM_AXIS SHALL be ignored; sub_block without masked stalled AXIS bit SHALL NOT contribute.

Reset
REQ-015 reset=1 at a rising edge SHALL force state IDLE, cnt=0, all outputs 0; reset overrides clear and any detection in that cycle.
REQ-016 reset mid-COUNTING or mid-DETECTED SHALL discard the run; counting restarts from 0 after release.

Verification
REQ-017 Defaults, axis_block_sigs=12'h010 held from cycle 5 -> block, block_sticky, detect_pulse=1 at cycle 6, first_idx=4, event_count=1; release at cycle 10 -> block=0 at cycle 11, sticky stays 1.
REQ-018 THRESHOLD=4, stall 3 cycles, gap 1, stall 4 cycles -> no detection after first run; block=1 on 4th cycle after second run start, event_count=1.
REQ-019 Defaults, axis bit 9 stalled, sub_block=2'b00 -> no block; sub_block=2'b10 -> block next cycle, first_idx=9; sub_block=2'b01 with only bit 9 -> no block.
REQ-020 Three separated detections, clear coincident with third entry -> event_count=1, first_valid=1, block_sticky=1.
REQ-021 EVT_W=2, five detections -> event_count saturates at 3; reset during DETECTED -> all outputs 0 next cycle, block reasserts one cycle after reset release if stall persists.
